// File: rtl/rx_packer_ctrl_256.sv
// rx_packer_ctrl_256
// Runs one 256-bit packer per receive transfer. It latches the requested
// length and admits 32-bit-word beats only while the downstream FIFO has at
// least C_RESERVE free entries. The final beat is clamped to the words still
// owed. After the last beat it spaces DONE/ERR and FLUSH so the packer
// pipeline drains, waits for the packer to confirm the flush, and then pulses
// a completion report.
module rx_packer_ctrl_256 #(
  parameter int C_RESERVE     = 4,
  parameter int C_FLUSH_DELAY = 2,
  parameter int C_LEN_W       = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic [C_LEN_W-1:0] REQ_LEN,
  output logic               REQ_READY,
  input  logic               ABORT,
  input  logic [255:0]       DATA_IN,
  input  logic [3:0]         DATA_IN_EN,
  output logic               DATA_READY,
  input  logic [7:0]         FIFO_FREE,
  output logic [255:0]       PK_DATA,
  output logic [3:0]         PK_DATA_EN,
  output logic               PK_DONE,
  output logic               PK_ERR,
  output logic               PK_FLUSH,
  input  logic               PK_FLUSHED,
  output logic               XFER_DONE,
  output logic [C_LEN_W-1:0] XFER_WORDS,
  output logic               XFER_ERR
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ACTIVE       = 3'd1,
    S_FLUSH_WAIT   = 3'd2,
    S_FLUSH        = 3'd3,
    S_WAIT_FLUSHED = 3'd4,
    S_DONE         = 3'd5
  } state_t;

  localparam logic [7:0] RESERVE_B = 8'(C_RESERVE);
  // A delay of 0 or 1 still spends one cycle in FLUSH_WAIT.
  localparam logic [7:0] DLY_LAST  = (C_FLUSH_DELAY > 1) ? 8'(C_FLUSH_DELAY - 1) : 8'd0;
  localparam logic [3:0] MAX_EN    = 4'd8;
  localparam logic [C_LEN_W-1:0] LEN_ZERO = {C_LEN_W{1'b0}};

  state_t             state_r;
  state_t             state_s;
  logic [C_LEN_W-1:0] remain_r;
  logic [C_LEN_W-1:0] count_r;
  logic               err_r;
  logic [7:0]         dly_cnt_r;

  logic [255:0]       pk_data_r;
  logic [3:0]         pk_data_en_r;
  logic               pk_done_r;
  logic               pk_err_r;
  logic               pk_flush_r;
  logic               xfer_done_r;
  logic [C_LEN_W-1:0] xfer_words_r;
  logic               xfer_err_r;

  logic               req_ready_s;
  logic               req_take_s;
  logic               accept_s;
  logic               abort_s;
  logic               en_legal_s;
  logic               overrun_s;
  logic               bad_beat_s;
  logic               last_s;
  logic [3:0]         fwd_s;
  logic [C_LEN_W-1:0] en_wide_s;
  logic [C_LEN_W-1:0] fwd_wide_s;

  // Admission decision and clamp of the accepted beat against the words still owed.
  always_comb begin
    req_ready_s = (state_r == S_IDLE);
    req_take_s  = req_ready_s && REQ;
    accept_s    = (state_r == S_ACTIVE) && (FIFO_FREE >= RESERVE_B);
    abort_s     = (state_r == S_ACTIVE) && ABORT;
    en_legal_s  = (DATA_IN_EN <= MAX_EN);
    en_wide_s   = C_LEN_W'(DATA_IN_EN);
    overrun_s   = 1'b0;
    fwd_s       = 4'd0;
    if (!accept_s) begin
      fwd_s = 4'd0;
    end else if (!en_legal_s) begin
      fwd_s = 4'd0;
    end else if (en_wide_s > remain_r) begin
      // remain_r is below 8 here, so its low nibble holds the whole value.
      fwd_s     = remain_r[3:0];
      overrun_s = 1'b1;
    end else begin
      fwd_s = DATA_IN_EN;
    end
    fwd_wide_s = C_LEN_W'(fwd_s);
    bad_beat_s = accept_s && (!en_legal_s || overrun_s);
    // remain_r is never zero while ACTIVE, so equality means this beat finishes the transfer.
    last_s     = accept_s && (fwd_wide_s == remain_r);
  end

  // Next-state selection for the transfer sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_take_s) begin
          if (REQ_LEN != LEN_ZERO) begin
            state_s = S_ACTIVE;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (last_s || abort_s) begin
          state_s = S_FLUSH_WAIT;
        end else begin
          state_s = S_ACTIVE;
        end
      end
      S_FLUSH_WAIT: begin
        if (dly_cnt_r >= DLY_LAST) begin
          state_s = S_FLUSH;
        end else begin
          state_s = S_FLUSH_WAIT;
        end
      end
      S_FLUSH: begin
        state_s = S_WAIT_FLUSHED;
      end
      S_WAIT_FLUSHED: begin
        if (PK_FLUSHED) begin
          state_s = S_DONE;
        end else begin
          state_s = S_WAIT_FLUSHED;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Flush spacing counter; it runs only while waiting out the packer pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dly_cnt_r <= 8'd0;
    end else if (state_r == S_FLUSH_WAIT) begin
      dly_cnt_r <= dly_cnt_r + 8'd1;
    end else begin
      dly_cnt_r <= 8'd0;
    end
  end

  // Transfer bookkeeping: words still owed, words forwarded, sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      remain_r <= LEN_ZERO;
      count_r  <= LEN_ZERO;
      err_r    <= 1'b0;
    end else if (req_take_s) begin
      remain_r <= REQ_LEN;
      count_r  <= LEN_ZERO;
      err_r    <= 1'b0;
    end else if (state_r == S_ACTIVE) begin
      remain_r <= remain_r - fwd_wide_s;
      count_r  <= count_r + fwd_wide_s;
      if (bad_beat_s || abort_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Registered packer controls and completion report.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pk_data_r    <= 256'd0;
      pk_data_en_r <= 4'd0;
      pk_done_r    <= 1'b0;
      pk_err_r     <= 1'b0;
      pk_flush_r   <= 1'b0;
      xfer_done_r  <= 1'b0;
      xfer_words_r <= LEN_ZERO;
      xfer_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        pk_data_r <= DATA_IN;
      end
      pk_data_en_r <= fwd_s;
      pk_done_r    <= last_s || abort_s;
      pk_err_r     <= abort_s;
      pk_flush_r   <= (state_r == S_FLUSH);
      xfer_done_r  <= (state_r == S_DONE);
      if (state_r == S_DONE) begin
        xfer_words_r <= count_r;
        xfer_err_r   <= err_r;
      end
    end
  end

  assign REQ_READY  = req_ready_s;
  assign DATA_READY = accept_s;
  assign PK_DATA    = pk_data_r;
  assign PK_DATA_EN = pk_data_en_r;
  assign PK_DONE    = pk_done_r;
  assign PK_ERR     = pk_err_r;
  assign PK_FLUSH   = pk_flush_r;
  assign XFER_DONE  = xfer_done_r;
  assign XFER_WORDS = xfer_words_r;
  assign XFER_ERR   = xfer_err_r;

endmodule

// File: doc/rx_packer_ctrl_256.md
Name: rx_packer_ctrl_256

Overview:
Sequences one 256-bit packer per receive transfer: latches a transfer length, admits upstream 32-bit-word beats only while the downstream FIFO has headroom, and clamps the final beat to the requested length. It then issues the packer's DONE/ERR/FLUSH controls with correct pipeline spacing and reports completion. It sits between the RX completion datapath and the 256-bit packer/FIFO pair, and supplies the "FIFO always has room" guarantee the packer relies on.

Parameters:
C_RESERVE, 4, minimum free FIFO entries (256-bit) required to admit a beat
C_FLUSH_DELAY, 2, idle cycles between last forwarded beat and PK_FLUSH pulse (covers packer input/mask pipeline)
C_LEN_W, 32, width of transfer length / word counters

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
REQ  in  1  start transfer (sampled when REQ_READY=1)
REQ_LEN  in  C_LEN_W  transfer length in 32-bit words
REQ_READY  out  1  controller idle, accepts REQ
ABORT  in  1  terminate active transfer with error
DATA_IN  in  256  upstream beat, words packed from bit 0
DATA_IN_EN  in  4  valid word count in beat, 0..8
DATA_READY  out  1  beat on DATA_IN/DATA_IN_EN consumed this cycle
FIFO_FREE  in  8  free FIFO entries
PK_DATA  out  256  to packer DATA_IN
PK_DATA_EN  out  4  to packer DATA_IN_EN
PK_DONE  out  1  to packer DATA_IN_DONE
PK_ERR  out  1  to packer DATA_IN_ERR
PK_FLUSH  out  1  to packer DATA_IN_FLUSH
PK_FLUSHED  in  1  from packer PACKED_DATA_FLUSHED
XFER_DONE  out  1  one-cycle completion pulse
XFER_WORDS  out  C_LEN_W  words forwarded, valid with XFER_DONE
XFER_ERR  out  1  error status, valid with XFER_DONE

Behaviour:
- Reset: state IDLE; REQ_READY=1, DATA_READY=0, PK_DATA_EN=0, PK_DONE=PK_ERR=PK_FLUSH=0, XFER_DONE=0, XFER_WORDS=0, XFER_ERR=0; remain/count/error registers cleared. Reset mid-transfer abandons it silently, no flush issued.
- All PK_* and XFER_* outputs registered; DATA_READY combinational from state and FIFO_FREE.
- States: IDLE, ACTIVE, FLUSH_WAIT, FLUSH, WAIT_FLUSHED, DONE.
- IDLE: REQ_READY=1. On REQ: latch remain=REQ_LEN, count=0, err=0. REQ_LEN!=0 -> ACTIVE. REQ_LEN=0 -> DONE directly, no packer activity.
- ACTIVE: DATA_READY = (FIFO_FREE >= C_RESERVE). Beat accepted when DATA_READY=1; beats with EN=0 are accepted and ignored.
  - EN>8: illegal; forwarded as 0 words, err=1.
  - fwd = min(EN, remain). EN>remain sets err=1 (overrun); excess words dropped.
  - Next cycle: PK_DATA=DATA_IN, PK_DATA_EN=fwd. remain-=fwd, count+=fwd. Cycles without acceptance give PK_DATA_EN=0.
  - remain reaching 0: PK_DONE=1 in the same cycle as the last PK_DATA_EN. Go to FLUSH_WAIT.
  - ABORT (ACTIVE only): PK_ERR=1 and PK_DONE=1 next cycle; err=1; go to FLUSH_WAIT. Same-cycle ABORT and beat: beat is forwarded (clamped), then abort.
- FLUSH_WAIT: DATA_READY=0; wait C_FLUSH_DELAY cycles, then go to FLUSH.
- FLUSH: PK_FLUSH=1 for exactly one cycle, then go to WAIT_FLUSHED.
- WAIT_FLUSHED: wait for PK_FLUSHED=1; no timeout.
- DONE: XFER_DONE=1 for one cycle with XFER_WORDS=count and XFER_ERR=err, then go to IDLE. REQ is not accepted in DONE.
- REQ/ABORT are ignored outside IDLE/ACTIVE respectively.
- Counters use C_LEN_W-bit arithmetic; remain never underflows because of the clamp.
- FIFO_FREE dropping below C_RESERVE mid-transfer only stalls admission; there is no state change.

Test Plan:
- REQ_LEN=16, two beats EN=8, FIFO_FREE=32 -> PK_DATA_EN 8,8; PK_DONE with second; PK_FLUSH 2 cycles later; XFER_DONE with XFER_WORDS=16, XFER_ERR=0.
- REQ_LEN=5, beats EN=3,3 -> PK_DATA_EN 3,2 with PK_DONE on second; XFER_WORDS=5, XFER_ERR=1.
- REQ_LEN=24, FIFO_FREE=2 for 10 cycles then 8 -> DATA_READY=0 and no PK_DATA_EN for 10 cycles; transfer then completes with XFER_WORDS=24.
- REQ_LEN=100, forward 12 words, then ABORT -> PK_ERR=PK_DONE=1 one cycle, PK_FLUSH, XFER_WORDS=12, XFER_ERR=1.
- REQ_LEN=0 -> XFER_DONE 2 cycles after REQ with XFER_WORDS=0; PK_FLUSH never asserted.
- RST asserted in WAIT_FLUSHED, and a beat with EN=9 in a fresh transfer -> after RST all outputs are at reset values and REQ_READY=1; the EN=9 beat is forwarded as 0 words and sets XFER_ERR=1.
